// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants and datapath selector types.
// Imported by the core and the register file.
package rv32_pkg;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   localparam logic [2:0] F3Beq  = 3'b000;
   localparam logic [2:0] F3Bne  = 3'b001;
   localparam logic [2:0] F3Blt  = 3'b100;
   localparam logic [2:0] F3Bge  = 3'b101;
   localparam logic [2:0] F3Bltu = 3'b110;
   localparam logic [2:0] F3Bgeu = 3'b111;

   localparam logic [2:0] F3Lb  = 3'b000;
   localparam logic [2:0] F3Lh  = 3'b001;
   localparam logic [2:0] F3Lw  = 3'b010;
   localparam logic [2:0] F3Lbu = 3'b100;
   localparam logic [2:0] F3Lhu = 3'b101;

   localparam logic [2:0] F3Sb = 3'b000;
   localparam logic [2:0] F3Sh = 3'b001;
   localparam logic [2:0] F3Sw = 3'b010;

   localparam logic [2:0] F3AddSub = 3'b000;
   localparam logic [2:0] F3Sll    = 3'b001;
   localparam logic [2:0] F3Slt    = 3'b010;
   localparam logic [2:0] F3Sltu   = 3'b011;
   localparam logic [2:0] F3Xor    = 3'b100;
   localparam logic [2:0] F3SrlSra = 3'b101;
   localparam logic [2:0] F3Or     = 3'b110;
   localparam logic [2:0] F3And    = 3'b111;

   localparam logic [6:0] F7Base = 7'b0000000;
   localparam logic [6:0] F7Alt  = 7'b0100000;

   typedef enum logic [3:0] {
      AluAdd,
      AluSub,
      AluSll,
      AluSlt,
      AluSltu,
      AluXor,
      AluSrl,
      AluSra,
      AluOr,
      AluAnd
   } alu_op_e;

   typedef enum logic [1:0] {
      WbAlu,
      WbMem,
      WbPc4
   } wb_sel_e;

   // alt selects SUB for funct3 000 and SRA for funct3 101.
   function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         F3AddSub: op = alt ? AluSub : AluAdd;
         F3Sll:    op = AluSll;
         F3Slt:    op = AluSlt;
         F3Sltu:   op = AluSltu;
         F3Xor:    op = AluXor;
         F3SrlSra: op = alt ? AluSra : AluSrl;
         F3Or:     op = AluOr;
         default:  op = AluAnd;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two operand read ports, one debug read port, one write port.
// x0 reads as zero; a write is visible only after its edge.
module regfile
   import rv32_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   input  logic [4:0]  ra3_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   output logic [31:0] rd3_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);

   logic [31:0] regs_q [32];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (wa_i != 5'd0)) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   always_comb begin
      rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
      rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];
      rd3_o = (ra3_i == 5'd0) ? 32'd0 : regs_q[ra3_i];
   end

endmodule

// File: rtl/cpu_top_verify.sv
// Single-cycle RV32I core: fetch from external imem, decode, execute and commit per edge.
// Holds the ALU, decoder and word-organised data memory; registers live in regfile.
module cpu_top_verify
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned DMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_out,
   input  logic [4:0]  ra3,
   output logic [31:0] rd3
);

   localparam int unsigned DmemAw = $clog2(DMEM_WORDS);

   logic [31:0] pc_q, pc_d, pc_plus4;
   logic [31:0] instr;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_data, rs2_data;
   logic [31:0] alu_a, alu_b, alu_res;
   alu_op_e     alu_op;
   wb_sel_e     wb_sel;
   logic        rf_we, mem_we, br_taken;
   logic [31:0] jalr_tgt, wb_data;

   logic [31:0]       dmem_q [DMEM_WORDS];
   logic [DmemAw-1:0] mem_idx;
   logic [31:0]       mem_word, mem_wdata, load_data;
   logic [3:0]        mem_be;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;

   assign instr     = imem_out;
   assign imem_addr = pc_q;
   assign pc_plus4  = pc_q + 32'd4;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'd0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Computed apart from the ALU so next-PC logic never loops through the decoder.
   assign jalr_tgt = (rs1_data + imm_i) & ~32'd1;

   regfile u_regfile (
      .clk_i (clk),
      .rst_i (rst),
      .ra1_i (rs1),
      .ra2_i (rs2),
      .ra3_i (ra3),
      .rd1_o (rs1_data),
      .rd2_o (rs2_data),
      .rd3_o (rd3),
      .we_i  (rf_we & ~rst),
      .wa_i  (rd),
      .wd_i  (wb_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_comb begin
      case (funct3)
         F3Beq:   br_taken = (rs1_data == rs2_data);
         F3Bne:   br_taken = (rs1_data != rs2_data);
         F3Blt:   br_taken = ($signed(rs1_data) < $signed(rs2_data));
         F3Bge:   br_taken = ($signed(rs1_data) >= $signed(rs2_data));
         F3Bltu:  br_taken = (rs1_data < rs2_data);
         F3Bgeu:  br_taken = (rs1_data >= rs2_data);
         default: br_taken = 1'b0;
      endcase
   end

   // Main decoder: anything not matched below retires as a NOP.
   always_comb begin
      alu_a  = rs1_data;
      alu_b  = imm_i;
      alu_op = AluAdd;
      wb_sel = WbAlu;
      rf_we  = 1'b0;
      mem_we = 1'b0;
      pc_d   = pc_plus4;
      case (opcode)
         OpLui: begin
            alu_a = 32'd0;
            alu_b = imm_u;
            rf_we = 1'b1;
         end
         OpAuipc: begin
            alu_a = pc_q;
            alu_b = imm_u;
            rf_we = 1'b1;
         end
         OpJal: begin
            wb_sel = WbPc4;
            rf_we  = 1'b1;
            pc_d   = pc_q + imm_j;
         end
         OpJalr: begin
            if (funct3 == 3'b000) begin
               wb_sel = WbPc4;
               rf_we  = 1'b1;
               pc_d   = jalr_tgt;
            end
         end
         OpBranch: begin
            if (br_taken) begin
               pc_d = pc_q + imm_b;
            end
         end
         OpLoad: begin
            wb_sel = WbMem;
            rf_we  = (funct3 == F3Lb) || (funct3 == F3Lh) || (funct3 == F3Lw) ||
                     (funct3 == F3Lbu) || (funct3 == F3Lhu);
         end
         OpStore: begin
            alu_b  = imm_s;
            mem_we = (funct3 == F3Sb) || (funct3 == F3Sh) || (funct3 == F3Sw);
         end
         OpImm: begin
            alu_op = alu_op_from_f3(funct3, (funct3 == F3SrlSra) && instr[30]);
            if (funct3 == F3Sll) begin
               rf_we = (funct7 == F7Base);
            end else if (funct3 == F3SrlSra) begin
               rf_we = (funct7 == F7Base) || (funct7 == F7Alt);
            end else begin
               rf_we = 1'b1;
            end
         end
         OpReg: begin
            alu_b  = rs2_data;
            alu_op = alu_op_from_f3(funct3, funct7 == F7Alt);
            rf_we  = (funct7 == F7Base) ||
                     ((funct7 == F7Alt) && ((funct3 == F3AddSub) || (funct3 == F3SrlSra)));
         end
         default: ;
      endcase
   end

   always_comb begin
      case (alu_op)
         AluAdd:  alu_res = alu_a + alu_b;
         AluSub:  alu_res = alu_a - alu_b;
         AluSll:  alu_res = alu_a << alu_b[4:0];
         AluSlt:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
         AluSltu: alu_res = {31'd0, alu_a < alu_b};
         AluXor:  alu_res = alu_a ^ alu_b;
         AluSrl:  alu_res = alu_a >> alu_b[4:0];
         AluSra:  alu_res = $signed(alu_a) >>> alu_b[4:0];
         AluOr:   alu_res = alu_a | alu_b;
         default: alu_res = alu_a & alu_b;
      endcase
   end

   // Word index drops the byte offset and wraps naturally at the memory size.
   assign mem_idx  = alu_res[DmemAw+1:2];
   assign mem_word = dmem_q[mem_idx];

   always_comb begin
      case (alu_res[1:0])
         2'd0:    ld_byte = mem_word[7:0];
         2'd1:    ld_byte = mem_word[15:8];
         2'd2:    ld_byte = mem_word[23:16];
         default: ld_byte = mem_word[31:24];
      endcase
      ld_half = alu_res[1] ? mem_word[31:16] : mem_word[15:0];
      case (funct3)
         F3Lb:    load_data = {{24{ld_byte[7]}}, ld_byte};
         F3Lh:    load_data = {{16{ld_half[15]}}, ld_half};
         F3Lbu:   load_data = {24'd0, ld_byte};
         F3Lhu:   load_data = {16'd0, ld_half};
         default: load_data = mem_word;
      endcase
   end

   always_comb begin
      mem_be    = 4'b1111;
      mem_wdata = rs2_data;
      case (funct3)
         F3Sb: begin
            mem_be    = 4'b0001 << alu_res[1:0];
            mem_wdata = {4{rs2_data[7:0]}};
         end
         F3Sh: begin
            mem_be    = alu_res[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{rs2_data[15:0]}};
         end
         default: ;
      endcase
   end

   // No reset on data memory: contents survive a core reset.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) begin
               dmem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      case (wb_sel)
         WbMem:   wb_data = load_data;
         WbPc4:   wb_data = pc_plus4;
         default: wb_data = alu_res;
      endcase
   end

endmodule

// File: tb/tb_cpu_top_verify.sv
// Directed bench for cpu_top_verify: a table of one-instruction steps with expected
// debug-read value and next PC, plus hand-written reset and control-flow sequences.
module tb_cpu_top_verify;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_out = 32'h0000_0013;
   logic [4:0]  ra3 = 5'd0;
   logic [31:0] rd3;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  ra3;
      logic [31:0] exp_rd3;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[$];

   cpu_top_verify #(
      .RESET_PC   (32'h0000_0000),
      .DMEM_WORDS (256)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .imem_addr (imem_addr),
      .imem_out  (imem_out),
      .ra3       (ra3),
      .rd3       (rd3)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic add(input logic [31:0] instr, input logic [4:0] r,
                      input logic [31:0] exp_rd3, input logic [31:0] exp_pc);
      vec_t v;
      v.instr   = instr;
      v.ra3     = r;
      v.exp_rd3 = exp_rd3;
      v.exp_pc  = exp_pc;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Present one instruction for one edge; outputs sampled 1 time unit after the edge.
   task automatic step(input logic [31:0] instr, input logic [4:0] r, input logic do_rst);
      @(negedge clk);
      imem_out = instr;
      ra3      = r;
      rst      = do_rst;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // pc after each step in last column
      add(32'h00F0_0093,                         5'd1,  32'h0000_000F, 32'd4);
      add(32'h0100_B193,                         5'd3,  32'h0000_0001, 32'd8);
      add(32'h0100_0093,                         5'd1,  32'h0000_0010, 32'd12);
      add(32'h0100_B193,                         5'd3,  32'h0000_0000, 32'd16);
      add(32'hFFF0_0093,                         5'd1,  32'hFFFF_FFFF, 32'd20);
      add(32'hFFF0_B193,                         5'd3,  32'h0000_0000, 32'd24);
      add(enc_i(12'h000, 5'd1, 3'd3, 5'd3, 7'h13), 5'd3, 32'h0000_0000, 32'd28);
      add(enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, 7'h13), 5'd1, 32'hFFFF_FFFB, 32'd32);
      add(32'h0050_B193,                         5'd3,  32'h0000_0000, 32'd36);
      add(enc_i(12'h000, 5'd0, 3'd0, 5'd1, 7'h13), 5'd1, 32'h0000_0000, 32'd40);
      add(enc_i(12'h003, 5'd1, 3'd3, 5'd3, 7'h13), 5'd3, 32'h0000_0001, 32'd44);
      add(enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, 7'h13), 5'd1, 32'hFFFF_FFFB, 32'd48);
      add(enc_i(12'h005, 5'd1, 3'd2, 5'd3, 7'h13), 5'd3, 32'h0000_0001, 32'd52);
      add(enc_u(20'h12345, 5'd3, 7'h37),            5'd3, 32'h1234_5000, 32'd56);
      add(enc_i(12'h678, 5'd3, 3'd0, 5'd3, 7'h13), 5'd3, 32'h1234_5678, 32'd60);
      add(enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd4),    5'd4, 32'h1234_5678, 32'd64);
      add(enc_r(7'h20, 5'd3, 5'd0, 3'd0, 5'd5),    5'd5, 32'hEDCB_A988, 32'd68);
      add(enc_i(12'h005, 5'd0, 3'd0, 5'd0, 7'h13), 5'd0, 32'h0000_0000, 32'd72);
      add(enc_s(12'h004, 5'd3, 5'd0, 3'd2),        5'd3, 32'h1234_5678, 32'd76);
      add(enc_i(12'h004, 5'd0, 3'd2, 5'd6, 7'h03), 5'd6, 32'h1234_5678, 32'd80);
      add(enc_i(12'h080, 5'd0, 3'd0, 5'd7, 7'h13), 5'd7, 32'h0000_0080, 32'd84);
      add(enc_s(12'h004, 5'd7, 5'd0, 3'd0),        5'd7, 32'h0000_0080, 32'd88);
      add(enc_i(12'h004, 5'd0, 3'd0, 5'd8, 7'h03), 5'd8, 32'hFFFF_FF80, 32'd92);
      add(enc_i(12'h004, 5'd0, 3'd4, 5'd8, 7'h03), 5'd8, 32'h0000_0080, 32'd96);
      add(enc_i(12'h004, 5'd0, 3'd2, 5'd8, 7'h03), 5'd8, 32'h1234_5680, 32'd100);
      add(enc_i(12'h006, 5'd0, 3'd1, 5'd9, 7'h03), 5'd9, 32'h0000_1234, 32'd104);
      add(enc_s(12'h007, 5'd7, 5'd0, 3'd0),        5'd9, 32'h0000_1234, 32'd108);
      add(enc_i(12'h006, 5'd0, 3'd1, 5'd9, 7'h03), 5'd9, 32'hFFFF_8034, 32'd112);
      add(enc_i(12'h006, 5'd0, 3'd5, 5'd9, 7'h03), 5'd9, 32'h0000_8034, 32'd116);
      add(enc_i(12'h404, 5'd5, 3'd5, 5'd10, 7'h13), 5'd10, 32'hFEDC_BA98, 32'd120);
      add(enc_i(12'h004, 5'd5, 3'd5, 5'd10, 7'h13), 5'd10, 32'h0EDC_BA98, 32'd124);
      add(enc_i(12'h021, 5'd0, 3'd0, 5'd12, 7'h13), 5'd12, 32'h0000_0021, 32'd128);
      add(enc_r(7'h00, 5'd12, 5'd7, 3'd1, 5'd11),  5'd11, 32'h0000_0100, 32'd132);
      add(enc_r(7'h20, 5'd12, 5'd5, 3'd5, 5'd11),  5'd11, 32'hF6E5_D4C4, 32'd136);
      add(enc_r(7'h00, 5'd0, 5'd5, 3'd2, 5'd11),   5'd11, 32'h0000_0001, 32'd140);
      add(enc_r(7'h00, 5'd0, 5'd5, 3'd3, 5'd11),   5'd11, 32'h0000_0000, 32'd144);
      add(enc_i(12'h0FF, 5'd5, 3'd7, 5'd11, 7'h13), 5'd11, 32'h0000_0088, 32'd148);
      add(32'h0000_0073,                            5'd11, 32'h0000_0088, 32'd152);
      add(enc_u(20'h00001, 5'd13, 7'h17),           5'd13, 32'h0000_1098, 32'd156);
      add(enc_b(13'd12, 5'd0, 5'd5, 3'd4),          5'd13, 32'h0000_1098, 32'd168);
      add(enc_b(13'd12, 5'd0, 5'd5, 3'd6),          5'd13, 32'h0000_1098, 32'd172);
      add(enc_b(13'h1FF8, 5'd5, 5'd0, 3'd5),        5'd13, 32'h0000_1098, 32'd164);
      add(enc_b(13'd8, 5'd0, 5'd5, 3'd7),           5'd13, 32'h0000_1098, 32'd172);
      add(enc_i(12'hFFF, 5'd12, 3'd0, 5'd14, 7'h67), 5'd14, 32'h0000_00B0, 32'd32);

      // Initial reset
      step(32'h0000_0013, 5'd1, 1'b1);
      step(32'h0000_0013, 5'd1, 1'b1);
      check("reset_pc", imem_addr, 32'd0);
      check("reset_x1", rd3, 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].instr, vecs[i].ra3, 1'b0);
         check($sformatf("vec%0d_rd3", i), rd3, vecs[i].exp_rd3);
         check($sformatf("vec%0d_pc", i), imem_addr, vecs[i].exp_pc);
      end

      // Mid-program reset: the instruction presented during reset must not commit.
      step(32'h00F0_0093, 5'd0, 1'b1);
      check("midrst_pc", imem_addr, 32'd0);
      for (int r = 0; r < 32; r++) begin
         ra3 = 5'(r);
         #1;
         check($sformatf("midrst_x%0d", r), rd3, 32'd0);
      end
      step(32'h00F0_0093, 5'd1, 1'b0);
      check("first_commit_x1", rd3, 32'h0000_000F);
      check("first_commit_pc", imem_addr, 32'd4);

      // Taken beq then jal from PC 8
      step(32'h0000_0013, 5'd0, 1'b1);
      step(enc_b(13'd8, 5'd0, 5'd0, 3'd0), 5'd3, 1'b0);
      check("beq_taken_pc", imem_addr, 32'd8);
      step(enc_j(21'd16, 5'd3), 5'd3, 1'b0);
      check("jal_pc", imem_addr, 32'd24);
      check("jal_link", rd3, 32'd12);

      // Not-taken bne, then data memory survives reset and wraps by size
      step(32'h0000_0013, 5'd0, 1'b1);
      step(enc_b(13'd8, 5'd0, 5'd0, 3'd1), 5'd0, 1'b0);
      check("bne_not_taken_pc", imem_addr, 32'd4);
      step(enc_i(12'h004, 5'd0, 3'd2, 5'd15, 7'h03), 5'd15, 1'b0);
      check("dmem_kept_over_reset", rd3, 32'h8034_5680);
      step(enc_s(12'h408, 5'd15, 5'd0, 3'd2), 5'd15, 1'b0);
      step(enc_i(12'h008, 5'd0, 3'd2, 5'd16, 7'h03), 5'd16, 1'b0);
      check("dmem_wrap", rd3, 32'h8034_5680);
      check("dmem_wrap_pc", imem_addr, 32'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_top_verify.md
CPU_TOP_VERIFY -- requirements
Module: cpu_top_verify

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter DMEM_WORDS, default 256, depth of internal 32-bit data memory.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port imem_addr, output, 32, current PC (byte address) presented to external instruction memory.
REQ-006 SHALL have port imem_out, input, 32, instruction word at imem_addr; sampled combinationally in the same cycle.
REQ-007 SHALL have port ra3, input, 5, debug register-file read address.
REQ-008 SHALL have port rd3, output, 32, debug read data: combinational value of x[ra3], 0 when ra3 = 0.

Function
REQ-009 SHALL be a single-cycle RV32I core: the instruction on imem_out is decoded and executed, and its results committed, at the next rising clk edge.
REQ-010 SHALL implement LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
REQ-011 SHALL treat FENCE, ECALL, EBREAK and any unrecognised opcode as NOP (PC+4, no writes).
REQ-012 SHALL sign-extend all I/S/B/U/J immediates to 32 bits per the RV32I encoding.
REQ-013 SLTIU/SLTU SHALL compare unsigned after sign-extension of the immediate (imm 0xFFF compares against 0xFFFF_FFFF); SLT/SLTI signed; result 1 or 0.
REQ-014 Shift amounts SHALL use the low 5 bits of rs2/shamt; SRA/SRAI arithmetic.
REQ-015 Arithmetic SHALL wrap modulo 2^32; no overflow traps.
REQ-016 Next PC SHALL be PC+4, branch target PC+immB when taken, PC+immJ for JAL, (rs1+immI) & ~1 for JALR; JAL/JALR write PC+4 to rd.
REQ-017 Misaligned targets SHALL be fetched as-is without a trap.
REQ-018 Register file: 32x32, two combinational read ports plus debug port ra3; one write port at rising edge; writes to x0 ignored; x0 reads 0.
REQ-019 Debug read SHALL reflect the pre-edge value until the write edge (no bypass of the current cycle's write).
REQ-020 Data memory: DMEM_WORDS words, word-indexed by addr[log2(DMEM_WORDS)+1:2], addresses wrap modulo size; combinational read, write at rising edge.
REQ-021 Sub-word stores SHALL use byte enables from addr[1:0]; loads SHALL extract by addr[1:0] and sign/zero-extend per opcode; misaligned halfword/word accesses use aligned word with addr[1:0] ignored for LW/SW, addr[1] for halfwords.

Reset
REQ-022 When rst is high at a rising edge, PC SHALL load RESET_PC and x1..x31 SHALL clear to 0; no instruction commits that cycle.
REQ-023 Data memory contents SHALL not be cleared by reset; initial contents are 0.
REQ-024 After rst deasserts, the first commit SHALL occur at the following rising edge.

Structure
REQ-025 Opcode, funct3/funct7 and ALU-op constants SHALL live in shared package rv32_pkg.
REQ-026 The register file SHALL be a sub-module named regfile (2 read + 1 debug read, 1 write); ALU, decode and data memory remain inside cpu_top_verify.

Verification
REQ-027 Reset, then addi x1,x0,15 (0x00F00093); sltiu x3,x1,16 (0x0100B193) -> rd3 (ra3=3) = 1; repeat with addi x1,x0,16 -> 0.
REQ-028 addi x1,x0,-1 (0xFFF00093); sltiu x3,x1,-1 (0xFFF0B193) -> 0; sltiu x3,x1,0 -> 0; addi x1,x0,-5; sltiu x3,x1,5 (0x0050B193) -> 0; x1=0, sltiu x3,x1,3 -> 1.
REQ-029 lui x3,0x12345; addi x3,x3,0x678 -> rd3 = 0x1234_5678; add/sub with x0 operand; write to x0 -> ra3=0 reads 0.
REQ-030 sw x3,4(x0); lb/lbu x3,4(x0) after storing 0x80 -> 0xFFFF_FF80 / 0x0000_0080; lw returns full word.
REQ-031 beq x0,x0,+8 at PC 0 -> imem_addr = 8 next cycle; bne x0,x0 -> 4; jal x3,+16 at PC 8 -> imem_addr 24, rd3 = 12.
REQ-032 Assert rst mid-program -> imem_addr = 0 and rd3 = 0 for every ra3 one edge later.
